// File: rtl/fpmul_arbiter.sv
// Two-requester round-robin front end for a shared single-precision multiplier.
// Only one multiply is ever outstanding. Results and flags are registered and returned to the owner.
module fpmul_arbiter (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req0,
  input  logic        Req1,
  input  logic [31:0] A0,
  input  logic [31:0] B0,
  input  logic [31:0] A1,
  input  logic [31:0] B1,
  output logic        Ack0,
  output logic        Ack1,
  output logic        Valid0,
  output logic        Valid1,
  output logic [31:0] Res,
  output logic [5:0]  Flags,
  output logic        Busy,
  output logic        MulStart,
  output logic [31:0] MulA,
  output logic [31:0] MulB,
  input  logic        MulDone,
  input  logic [31:0] MulP,
  input  logic        MulOF,
  input  logic        MulUF,
  input  logic        MulNaNF,
  input  logic        MulInfF,
  input  logic        MulDNF,
  input  logic        MulZF
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t state;
  logic   pri;
  logic   owner;
  logic   grant_any;
  logic   grant_sel;

  always_comb begin
    grant_any = Req0 | Req1;
    grant_sel = (Req0 && Req1) ? pri : Req1;
  end

  // Every output is registered. Ack and MulStart are raised together as the FSM enters START.
  // Valid is raised as the FSM leaves RESP.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      pri      <= 1'b0;
      owner    <= 1'b0;
      Ack0     <= 1'b0;
      Ack1     <= 1'b0;
      Valid0   <= 1'b0;
      Valid1   <= 1'b0;
      Busy     <= 1'b0;
      MulStart <= 1'b0;
      Res      <= '0;
      Flags    <= '0;
      MulA     <= '0;
      MulB     <= '0;
    end else begin
      Ack0     <= 1'b0;
      Ack1     <= 1'b0;
      Valid0   <= 1'b0;
      Valid1   <= 1'b0;
      MulStart <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner    <= grant_sel;
            MulA     <= grant_sel ? A1 : A0;
            MulB     <= grant_sel ? B1 : B0;
            Ack0     <= ~grant_sel;
            Ack1     <= grant_sel;
            MulStart <= 1'b1;
            Busy     <= 1'b1;
            state    <= START;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (MulDone) begin
            Res   <= MulP;
            Flags <= {MulOF, MulUF, MulNaNF, MulInfF, MulDNF, MulZF};
            state <= RESP;
          end
        end
        RESP: begin
          Valid0 <= ~owner;
          Valid1 <= owner;
          pri    <= ~owner;
          Busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed self-checking bench for fpmul_arbiter.
// The bench plays the part of the shared multiplier and returns hand-computed products.
module tb_fpmul_arbiter;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Req0 = 1'b0, Req1 = 1'b0;
  logic [31:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic        Ack0, Ack1, Valid0, Valid1, Busy, MulStart;
  logic [31:0] Res, MulA, MulB;
  logic [5:0]  Flags;
  logic        MulDone = 1'b0;
  logic [31:0] MulP = 32'hdeadbeef;
  logic [5:0]  mflags = '1;

  int n_checks = 0;
  int n_fail   = 0;

  int          o_ack_t, o_who, o_starts, o_vwho, o_lat, o_excl;
  bit          o_valid, o_busy_ack;
  logic [31:0] o_ma, o_mb;

  fpmul_arbiter dut (
    .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .Ack0(Ack0), .Ack1(Ack1), .Valid0(Valid0), .Valid1(Valid1),
    .Res(Res), .Flags(Flags), .Busy(Busy), .MulStart(MulStart),
    .MulA(MulA), .MulB(MulB), .MulDone(MulDone), .MulP(MulP),
    .MulOF(mflags[5]), .MulUF(mflags[4]), .MulNaNF(mflags[3]),
    .MulInfF(mflags[2]), .MulDNF(mflags[1]), .MulZF(mflags[0])
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Runs one operation with the caller's requests already raised. The multiplier answers
  // after n_wait WAIT cycles and returns junk in every other cycle.
  task automatic run_op(input int n_wait, input logic [31:0] p, input logic [5:0] f, input bit hold);
    int a_cyc, s_cyc;
    a_cyc = -1; s_cyc = -1;
    o_ack_t = -1; o_who = -1; o_starts = 0; o_vwho = -1; o_lat = -1; o_excl = 0;
    o_valid = 0; o_busy_ack = 0; o_ma = 'x; o_mb = 'x;
    for (int t = 0; t < 60 && !o_valid; t++) begin
      step();
      if (Ack0 && Ack1) o_excl++;
      if (Valid0 && Valid1) o_excl++;
      if ((Ack0 || Ack1) && a_cyc < 0) begin
        a_cyc = t; o_ack_t = t; o_who = Ack1 ? 1 : 0;
        o_ma = MulA; o_mb = MulB; o_busy_ack = Busy;
        if (!hold) begin
          if (Ack0) Req0 = 1'b0;
          else      Req1 = 1'b0;
        end
      end
      if (MulStart) begin o_starts++; s_cyc = t; end
      if (Valid0 || Valid1) begin
        o_valid = 1; o_vwho = Valid1 ? 1 : 0; o_lat = t - a_cyc + 1;
      end
      if (s_cyc >= 0 && t == s_cyc + n_wait) begin
        MulDone = 1'b1; MulP = p; mflags = f;
      end else begin
        MulDone = 1'b0; MulP = 32'hdeadbeef; mflags = '1;
      end
    end
    MulDone = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
    step(); step();
    n_checks++; if ({Ack0, Ack1, Valid0, Valid1} !== 4'b0) begin n_fail++; $display("FAIL reset_handshake: got %b want 0000", {Ack0, Ack1, Valid0, Valid1}); end
    n_checks++; if ({Busy, MulStart} !== 2'b0) begin n_fail++; $display("FAIL reset_busy_start: got %b want 00", {Busy, MulStart}); end
    n_checks++; if (Res !== 32'h0 || Flags !== 6'h0) begin n_fail++; $display("FAIL reset_res_flags: got %h/%b want 0/0", Res, Flags); end
    n_checks++; if (MulA !== 32'h0 || MulB !== 32'h0) begin n_fail++; $display("FAIL reset_operands: got %h/%h want 0/0", MulA, MulB); end
    Rst = 1'b0;
  endtask

  task automatic test_single_req0();
    A0 = 32'h40f903cc; B0 = 32'h40824fcd; Req0 = 1'b1;
    run_op(2, 32'h41fd831a, 6'b000000, 1'b0);
    n_checks++; if (o_who !== 0) begin n_fail++; $display("FAIL single_grant: got %0d want 0", o_who); end
    n_checks++; if (o_ma !== 32'h40f903cc || o_mb !== 32'h40824fcd) begin n_fail++; $display("FAIL single_operands: got %h/%h want 40f903cc/40824fcd", o_ma, o_mb); end
    n_checks++; if (o_busy_ack !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", o_busy_ack); end
    n_checks++; if (o_starts !== 1) begin n_fail++; $display("FAIL single_starts: got %0d want 1", o_starts); end
    n_checks++; if (!o_valid || o_vwho !== 0) begin n_fail++; $display("FAIL single_valid: got %0d/%0d want 1/0", o_valid, o_vwho); end
    n_checks++; if (o_lat !== 5) begin n_fail++; $display("FAIL single_latency: got %0d want 5", o_lat); end
    n_checks++; if (Res !== 32'h41fd831a || Flags !== 6'b0) begin n_fail++; $display("FAIL single_result: got %h/%b want 41fd831a/000000", Res, Flags); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b want 0", Busy); end
  endtask

  task automatic test_contention();
    // Both requests are held across reset; arbitration must start immediately with pointer 0.
    A0 = 32'h40000000; B0 = 32'h40000000; A1 = 32'h42000000; B1 = 32'h40000000;
    Req0 = 1'b1; Req1 = 1'b1; Rst = 1'b1;
    step(); step();
    Rst = 1'b0;
    run_op(1, 32'h40800000, 6'b0, 1'b1);
    n_checks++; if (o_ack_t !== 0 || o_who !== 0) begin n_fail++; $display("FAIL contend_first_grant: got t%0d/%0d want t0/0", o_ack_t, o_who); end
    n_checks++; if (o_vwho !== 0 || Res !== 32'h40800000) begin n_fail++; $display("FAIL contend_first_result: got %0d/%h want 0/40800000", o_vwho, Res); end
    n_checks++; if (o_lat !== 4) begin n_fail++; $display("FAIL contend_first_latency: got %0d want 4", o_lat); end
    run_op(3, 32'h42800000, 6'b0, 1'b1);
    n_checks++; if (o_who !== 1 || o_ma !== 32'h42000000 || o_mb !== 32'h40000000) begin n_fail++; $display("FAIL contend_second_grant: got %0d %h/%h want 1 42000000/40000000", o_who, o_ma, o_mb); end
    n_checks++; if (o_vwho !== 1 || Res !== 32'h42800000) begin n_fail++; $display("FAIL contend_second_result: got %0d/%h want 1/42800000", o_vwho, Res); end
    n_checks++; if (o_lat !== 6) begin n_fail++; $display("FAIL contend_second_latency: got %0d want 6", o_lat); end
    run_op(1, 32'h40800000, 6'b0, 1'b1);
    Req0 = 1'b0; Req1 = 1'b0;
    n_checks++; if (o_who !== 0 || o_vwho !== 0) begin n_fail++; $display("FAIL contend_third_grant: got %0d/%0d want 0/0", o_who, o_vwho); end
    n_checks++; if (o_excl !== 0) begin n_fail++; $display("FAIL contend_exclusive: got %0d want 0", o_excl); end
  endtask

  task automatic test_nan();
    A1 = 32'h319a90b8; B1 = 32'hffcd3697; Req1 = 1'b1;
    run_op(2, 32'hffcd3697, 6'b001000, 1'b0);
    n_checks++; if (o_who !== 1 || o_ma !== 32'h319a90b8 || o_mb !== 32'hffcd3697) begin n_fail++; $display("FAIL nan_operands: got %0d %h/%h want 1 319a90b8/ffcd3697", o_who, o_ma, o_mb); end
    n_checks++; if (o_vwho !== 1 || Res !== 32'hffcd3697 || Flags !== 6'b001000) begin n_fail++; $display("FAIL nan_result: got %0d %h/%b want 1 ffcd3697/001000", o_vwho, Res, Flags); end
  endtask

  task automatic test_inf();
    A0 = 32'ha5f93813; B0 = 32'h7f800000; Req0 = 1'b1;
    run_op(1, 32'hff800000, 6'b000100, 1'b0);
    n_checks++; if (o_ma !== 32'ha5f93813 || o_mb !== 32'h7f800000) begin n_fail++; $display("FAIL inf_operands: got %h/%h want a5f93813/7f800000", o_ma, o_mb); end
    n_checks++; if (o_vwho !== 0 || Res !== 32'hff800000 || Flags !== 6'b000100) begin n_fail++; $display("FAIL inf_result: got %0d %h/%b want 0 ff800000/000100", o_vwho, Res, Flags); end
    n_checks++; if (o_lat !== 4) begin n_fail++; $display("FAIL inf_latency: got %0d want 4", o_lat); end
  endtask

  task automatic test_back_to_back();
    A0 = 32'h3fc00000; B0 = 32'h40000000; Req0 = 1'b1;
    run_op(2, 32'h40400000, 6'b0, 1'b1);
    run_op(2, 32'h40400000, 6'b0, 1'b1);
    Req0 = 1'b0;
    n_checks++; if (o_ack_t !== 0 || o_who !== 0) begin n_fail++; $display("FAIL b2b_lone_regrant: got t%0d/%0d want t0/0", o_ack_t, o_who); end
    n_checks++; if (o_vwho !== 0 || Res !== 32'h40400000) begin n_fail++; $display("FAIL b2b_result: got %0d/%h want 0/40400000", o_vwho, Res); end
    MulP = 32'h55555555; mflags = '1;
    step(); step(); step();
    n_checks++; if (Res !== 32'h40400000 || Flags !== 6'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL b2b_hold: got %h/%b busy %b want 40400000/000000 busy 0", Res, Flags, Busy); end
  endtask

  task automatic test_spurious_done();
    int s, vt, vcnt, bcnt;
    logic [31:0] vres;
    logic [5:0]  vflg;
    MulDone = 1'b1; MulP = 32'h11111111; mflags = '1;
    bcnt = 0;
    repeat (3) begin
      step();
      if (Valid0 || Valid1 || Busy) bcnt++;
    end
    n_checks++; if (bcnt !== 0) begin n_fail++; $display("FAIL spurious_idle: got %0d active cycles want 0", bcnt); end
    A0 = 32'h3f800000; B0 = 32'h3f800000; Req0 = 1'b1;
    s = -1; vt = -1; vcnt = 0; vres = 'x; vflg = 'x;
    for (int t = 0; t < 30; t++) begin
      step();
      if (Ack0) Req0 = 1'b0;
      if (MulStart) s = t;
      if (Valid0 || Valid1) begin vcnt++; vt = t; vres = Res; vflg = Flags; end
      if (s >= 0 && t == s) begin
        MulDone = 1'b1; MulP = 32'h11111111; mflags = '1;
      end else if (s >= 0 && t == s + 3) begin
        MulDone = 1'b1; MulP = 32'h3f800000; mflags = 6'b0;
      end else if (s >= 0) begin
        MulDone = 1'b0; MulP = 32'hdeadbeef; mflags = '1;
      end
    end
    MulDone = 1'b0;
    n_checks++; if (vcnt !== 1) begin n_fail++; $display("FAIL spurious_valid_count: got %0d want 1", vcnt); end
    n_checks++; if (vt - s !== 5) begin n_fail++; $display("FAIL spurious_latency: got %0d want 5", vt - s); end
    n_checks++; if (vres !== 32'h3f800000 || vflg !== 6'b0) begin n_fail++; $display("FAIL spurious_result: got %h/%b want 3f800000/000000", vres, vflg); end
  endtask

  task automatic test_reset_abort();
    int s, vc, sc, bc;
    A0 = 32'h40400000; B0 = 32'h40400000; Req0 = 1'b1;
    s = -1;
    for (int t = 0; t < 10 && s < 0; t++) begin
      step();
      if (Ack0) Req0 = 1'b0;
      if (MulStart) s = t;
    end
    n_checks++; if (s < 0) begin n_fail++; $display("FAIL abort_start: got no MulStart want one"); end
    step(); step();
    n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_wait: got %b want 1", Busy); end
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    n_checks++; if (Busy !== 1'b0 || Res !== 32'h0 || MulA !== 32'h0) begin n_fail++; $display("FAIL abort_reset_state: got busy %b res %h mula %h want 0/0/0", Busy, Res, MulA); end
    vc = 0; sc = 0; bc = 0;
    for (int t = 0; t < 12; t++) begin
      if (t == 2) begin MulDone = 1'b1; MulP = 32'h41100000; mflags = '1; end
      else begin MulDone = 1'b0; MulP = 32'hdeadbeef; end
      step();
      if (Valid0 || Valid1) vc++;
      if (MulStart) sc++;
      if (Busy) bc++;
    end
    MulDone = 1'b0;
    n_checks++; if (vc !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d want 0", vc); end
    n_checks++; if (sc !== 0) begin n_fail++; $display("FAIL abort_no_restart: got %0d want 0", sc); end
    n_checks++; if (bc !== 0 || Res !== 32'h0 || Flags !== 6'h0) begin n_fail++; $display("FAIL abort_idle: got busy %0d res %h flags %b want 0/0/0", bc, Res, Flags); end
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_contention();
    test_nan();
    test_inf();
    test_back_to_back();
    test_spurious_done();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpmul_arbiter.md
FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

Interface
- REQ-001: The block SHALL have the following ports (name, direction, width, meaning).
  - Clk  in  1  single clock; all state updates on rising edge.
  - Rst  in  1  synchronous, active-high reset.
  - Req0, Req1  in  1 each  operation request from requester 0 / 1; held high until its Ack.
  - A0, B0, A1, B1  in  32 each  IEEE-754 single operands per requester; valid while Req high.
  - Ack0, Ack1  out  1 each  one-cycle pulse: request accepted, operands captured.
  - Valid0, Valid1  out  1 each  one-cycle pulse: result for requester 0 / 1 on Res/Flags.
  - Res  out  32  product.
  - Flags  out  6  {OF, UF, NaNF, InfF, DNF, ZF}.
  - Busy  out  1  high in every state except IDLE.
  - MulStart  out  1  start pulse to the shared FPMUL.
  - MulA, MulB  out  32 each  operands to FPMUL.
  - MulDone  in  1  FPMUL completion.
  - MulP  in  32  FPMUL product.
  - MulOF, MulUF, MulNaNF, MulInfF, MulDNF, MulZF  in  1 each  FPMUL status flags.

Function
- REQ-002: States SHALL be IDLE, START, WAIT, RESP; encoding is free.
- REQ-003: IDLE transitions:
  - No request: remain in IDLE.
  - Exactly one Req high: grant that requester.
  - Both high: grant the requester indicated by the priority pointer Pri (0 or 1).
- REQ-004: On grant in IDLE:
  - Latch the granted A/B into MulA/MulB and record the owner index.
  - Pulse the owner's Ack for that single cycle.
  - Next state START.
- REQ-005: START SHALL hold MulStart=1 for exactly one cycle, then go to WAIT.
- REQ-006: MulA/MulB SHALL stay stable from grant until RESP exits.
- REQ-007: WAIT SHALL sample MulDone only in WAIT; MulDone in any other state SHALL be ignored.
- REQ-008: WAIT SHALL stay until MulDone=1, with no timeout.
- REQ-009: On MulDone=1 in WAIT, the block SHALL latch MulP into Res and the six flags into Flags, then go to RESP.
- REQ-010: RESP SHALL pulse the owner's Valid for one cycle, set Pri to the non-owner, and return to IDLE.
- REQ-011: Total latency SHALL be N+3 cycles from Ack to Valid, where N is the number of WAIT cycles up to and including the MulDone cycle.
- REQ-012: Res/Flags SHALL hold their last value until the next RESP latch.
- REQ-013: A Req still high in the cycle after its Ack SHALL be treated as a new request, granted no earlier than the next IDLE.
- REQ-014: A Req that falls before Ack SHALL be dropped silently.
- REQ-015: Arbitration SHALL be round-robin.
  - Back-to-back contention alternates 0,1,0,1.
  - A lone requester may be granted consecutively.
- REQ-016: Ack0/Ack1 and Valid0/Valid1 SHALL each be mutually exclusive.
- REQ-017: At most one FPMUL operation SHALL be outstanding at any time.
- REQ-018: Operand values SHALL pass through unmodified, including NaN, Inf, denormal and zero.

Reset
- REQ-019: Rst=1 at a clock edge SHALL force:
  - State IDLE, Pri=0.
  - MulStart, Ack0, Ack1, Valid0, Valid1 and Busy all 0.
  - Res, Flags, MulA, MulB all zero.
- REQ-020: Rst asserted in START, WAIT or RESP SHALL abort the operation.
  - No Valid is issued for the aborted operation.
  - A later MulDone from the aborted operation is ignored because the block is in IDLE.
- REQ-021: Requests held across reset SHALL be arbitrated normally starting in the first cycle after Rst falls.

Verification
- REQ-022: Req0 alone, A0=0x40f903cc, B0=0x40824fcd -> Ack0, one MulStart, Valid0 with Res=0x41fd831a, Flags=0.
- REQ-023: Req0 and Req1 in the same cycle after reset, A0=B0=0x40000000, A1=0x42000000, B1=0x40000000 (both held high after their Acks):
  - First grant 0: Valid0, Res=0x40800000.
  - Then grant 1: Valid1, Res=0x42800000.
  - Then grant 0 again.
- REQ-024: Req1 alone, A1=0x319a90b8, B1=0xffcd3697 -> Valid1, NaNF=1, Res equals MulP unaltered.
- REQ-025: Req0 with A0=0xa5f93813, B0=0x7f800000 -> Valid0, Res=0xff800000, InfF=1.
- REQ-026: Rst pulsed during WAIT, MulDone raised two cycles later -> no Valid, Busy=0, MulStart never re-pulsed.
- REQ-027: MulDone forced high in IDLE and START -> ignored; exactly one Valid per MulDone seen in WAIT.
